// File: rtl/fsm_burst_read_pkg.sv
// Shared types and default sizing for the burst read sequencer.
package fsm_burst_pkg;

    localparam int DEF_MAX_LEN  = 16;
    localparam int DEF_MAX_WAIT = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        DLY  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/fsm_burst_read_wait_cnt.sv
// Saturating wait-state counter for one beat. Only built when the
// FSM_BURST_TIMEOUT_EN macro is defined.
// hit flags that the count reaches MAX_WAIT at the coming clock edge,
// so the sequencer can leave DLY on the same edge that records the
// final retry.
module fsm_wait_cnt
    import fsm_burst_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int W        = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment until saturated at MAX_WAIT.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != W'(MAX_WAIT))) begin
            count_d = count_q + W'(1);
        end
    end

    assign hit = (count_d == W'(MAX_WAIT));

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fsm_burst_read.sv
// Burst read sequencer: issues 1..MAX_LEN read beats per start request,
// retrying a beat while the target asserts ws. Outputs are registered
// and decoded from the next state.
// Optional feature macro: FSM_BURST_TIMEOUT_EN -- when defined, MAX_WAIT
// consecutive ws=1 retries on one beat terminate the burst through ERR.
module fsm_burst_read
    import fsm_burst_pkg::*;
#(
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int LEN_W    = $clog2(MAX_LEN),
    parameter int CNT_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             ws,
    output logic             rd,
    output logic             ds,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] beat_cnt
);

    // Elaboration-time guards on the configuration.
    if ((MAX_LEN < 2) || ((MAX_LEN & (MAX_LEN - 1)) != 0)) begin : g_bad_max_len
        $error("fsm_burst_read: MAX_LEN must be a power of two >= 2");
    end
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("fsm_burst_read: MAX_WAIT must be >= 1");
    end

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             ds_q, ds_d;
    logic             busy_q, busy_d;

`ifdef FSM_BURST_TIMEOUT_EN
    logic err_q, err_d;
    logic wait_inc, wait_clr, wait_hit;

    // Count retries on the current beat; restart on a new burst or a completed beat.
    assign wait_inc = (state_q == DLY) && ws;
    assign wait_clr = ((state_q == IDLE) && start) || ((state_q == DLY) && !ws);

    fsm_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .hit   (wait_hit)
    );
`endif

    // Next-state logic: burst acceptance, beat retry/complete, termination.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    len_d   = len;
                    cnt_d   = '0;
                end
            end
            READ: state_d = DLY;
            DLY: begin
                if (ws) begin
`ifdef FSM_BURST_TIMEOUT_EN
                    state_d = wait_hit ? ERR : READ;
`else
                    state_d = READ;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    // Last beat completes when the beats done so far equal len.
                    state_d = (cnt_q == CNT_W'(len_q)) ? DONE : READ;
                end
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode from the next state so outputs track the state they enter with.
    always_comb begin
        rd_d   = (state_d == READ) || (state_d == DLY);
        ds_d   = (state_d == DONE) || (state_d == ERR);
        busy_d = (state_d != IDLE);
`ifdef FSM_BURST_TIMEOUT_EN
        err_d  = (state_d == ERR);
`endif
    end

    // State, beat count and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            ds_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FSM_BURST_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ds_q    <= ds_d;
            busy_q  <= busy_d;
`ifdef FSM_BURST_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Latched burst length.
    always_ff @(posedge clk) begin
        // NOTE: len_q is only read after IDLE loads it with start, so it carries no reset.
        len_q <= len_d;
    end

    assign rd       = rd_q;
    assign ds       = ds_q;
    assign busy     = busy_q;
    assign beat_cnt = cnt_q;
`ifdef FSM_BURST_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_burst_read.sv
// Self-checking bench for fsm_burst_read. A transaction-level model expands
// each burst (length plus per-beat retry counts) into the expected per-cycle
// output trace; directed cases are followed by randomized bursts.
// Honours FSM_BURST_TIMEOUT_EN the same way the design does.
module tb_fsm_burst_read;

    localparam int MAX_LEN  = 16;
    localparam int MAX_WAIT = 8;
    localparam int LEN_W    = 4;
    localparam int CNT_W    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             ws;
    logic             rd, ds, busy, err;
    logic [CNT_W-1:0] beat_cnt;

    fsm_burst_read #(
        .MAX_LEN  (MAX_LEN),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .ws       (ws),
        .rd       (rd),
        .ds       (ds),
        .busy     (busy),
        .err      (err),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    // One expected cycle: outputs after an edge, plus ws to drive during it (-1 = don't care).
    typedef struct {
        logic rd;
        logic ds;
        logic busy;
        logic err;
        int   cnt;
        int   ws;
    } exp_t;

    exp_t trace[$];
    int   retries[MAX_LEN];
    int   last_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".rd"},       32'(rd),       32'(e.rd));
        check({tag, ".ds"},       32'(ds),       32'(e.ds));
        check({tag, ".busy"},     32'(busy),     32'(e.busy));
        check({tag, ".err"},      32'(err),      32'(e.err));
        check({tag, ".beat_cnt"}, 32'(beat_cnt), 32'(e.cnt));
    endtask

    function automatic exp_t mk(logic r, logic d, logic b, logic e, int c, int w);
        exp_t x;
        x.rd = r; x.ds = d; x.busy = b; x.err = e; x.cnt = c; x.ws = w;
        return x;
    endfunction

    // Expand a burst of l+1 beats with retries[] per beat into the expected trace.
    // Every read attempt is two rd cycles; the second carries the ws answer.
    function automatic void build_trace(int l);
        int done = 0;
        trace.delete();
        for (int b = 0; b <= l; b++) begin
            for (int k = 0; k <= retries[b]; k++) begin
                bit retry = (k < retries[b]);
                trace.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, done, -1));
                trace.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, done, retry ? 1 : 0));
`ifdef FSM_BURST_TIMEOUT_EN
                if (retry && (k == MAX_WAIT - 1)) begin
                    trace.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, done, -1));
                    last_cnt = done;
                    return;
                end
`endif
                if (!retry) done++;
            end
        end
        trace.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, done, -1));
        last_cnt = done;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            len   = LEN_W'($urandom);
            ws    = 1'($urandom);
            @(posedge clk); #1;
            check_out("idle", mk(1'b0, 1'b0, 1'b0, 1'b0, last_cnt, -1));
        end
    endtask

    // Run one burst from IDLE. abort_at >= 0 applies a one-edge reset after that trace cycle.
    task automatic run_burst(input int l, input int abort_at);
        build_trace(l);
        for (int j = 0; j < trace.size(); j++) begin
            if (j == 0) begin
                start = 1'b1;
                len   = LEN_W'(l);
                ws    = 1'($urandom);
            end else begin
                start = 1'($urandom);
                len   = LEN_W'($urandom);
                ws    = (trace[j-1].ws < 0) ? 1'($urandom) : 1'(trace[j-1].ws);
            end
            @(posedge clk); #1;
            check_out($sformatf("len%0d.c%0d", l, j), trace[j]);
            if (j == abort_at) begin
                rst_n = 1'b0;
                start = 1'($urandom);
                ws    = 1'($urandom);
                @(posedge clk); #1;
                last_cnt = 0;
                check_out("reset_mid", mk(1'b0, 1'b0, 1'b0, 1'b0, 0, -1));
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
        end
        start = 1'($urandom);
        len   = LEN_W'($urandom);
        ws    = 1'($urandom);
        @(posedge clk); #1;
        check_out($sformatf("len%0d.end", l), mk(1'b0, 1'b0, 1'b0, 1'b0, last_cnt, -1));
        start = 1'b0;
    endtask

    task automatic clear_retries();
        for (int b = 0; b < MAX_LEN; b++) retries[b] = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        ws    = 1'b0;
        clear_retries();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", mk(1'b0, 1'b0, 1'b0, 1'b0, 0, -1));
        rst_n = 1'b1;
        idle_cycles(1);

        // Single beat, no waits.
        run_burst(0, -1);
        // Four beats back to back.
        run_burst(3, -1);
        idle_cycles(2);
        // Two retries on the first beat of a two-beat burst.
        retries[0] = 2;
        run_burst(1, -1);
        // ws stuck high: timeout to ERR, or long retrying without timeout.
        retries[0] = 60;
        run_burst(0, -1);
        clear_retries();
        idle_cycles(1);
        // Maximum length burst, started back to back.
        run_burst(MAX_LEN - 1, -1);
        // Reset during DLY of the second beat, then a fresh single beat.
        run_burst(3, 3);
        run_burst(0, -1);

        // Randomized bursts with occasional long or timing-out retry runs.
        for (int n = 0; n < 40; n++) begin
            int l = $urandom_range(0, MAX_LEN - 1);
            for (int b = 0; b < MAX_LEN; b++) begin
                if ($urandom_range(0, 7) == 0)
                    retries[b] = $urandom_range(MAX_WAIT - 1, MAX_WAIT + 2);
                else
                    retries[b] = $urandom_range(0, 3);
            end
            run_burst(l, -1);
            idle_cycles($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
